// File: rtl/multiplicity_window_detector.sv
// multiplicity_window_detector
// Reports, one cycle after each accepted symbol, how often that symbol occurs
// among the last DEPTH accepted symbols (window mode) or in the current run of
// identical symbols (run mode). The result includes the symbol itself.
// Optional feature macro: MULT_DETECT_EVENT_CNT_EN adds saturating pair/triple
// event counters (pair_cnt, triple_cnt).
module multiplicity_window_detector #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 7,
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          mode,
  input  logic                          clear,
  output logic                          out_valid,
  output logic [$clog2(DEPTH+2)-1:0]    out_mult,
  output logic                          out_pair,
  output logic                          out_triple,
  output logic                          out_many
`ifdef MULT_DETECT_EVENT_CNT_EN
  ,
  output logic [CNT_W-1:0]              pair_cnt,
  output logic [CNT_W-1:0]              triple_cnt
`endif
);

  localparam int MW = $clog2(DEPTH+2);

  // History: entry 0 is the newest symbol.
  logic [DEPTH-1:0]            hist_vld;
  logic [DEPTH-1:0][WIDTH-1:0] hist_data;

  // Stage p0 (combinational, evaluated against history before the shift).
  logic [DEPTH-1:0] vld_eff_p0;
  logic [MW-1:0]    mult_p0;

  // Matches anywhere in the valid part of the history.
  function automatic logic [MW-1:0] window_count(
    input logic [DEPTH-1:0]            v,
    input logic [DEPTH-1:0][WIDTH-1:0] d,
    input logic [WIDTH-1:0]            sym
  );
    logic [MW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (v[i] && (d[i] == sym)) cnt = cnt + MW'(1);
    end
    return cnt;
  endfunction

  // Matches in the unbroken run starting at the newest entry.
  function automatic logic [MW-1:0] run_count(
    input logic [DEPTH-1:0]            v,
    input logic [DEPTH-1:0][WIDTH-1:0] d,
    input logic [WIDTH-1:0]            sym
  );
    logic [MW-1:0] cnt;
    logic          run_on;
    cnt    = '0;
    run_on = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (run_on && v[i] && (d[i] == sym)) cnt = cnt + MW'(1);
      else                                 run_on = 1'b0;
    end
    return cnt;
  endfunction

  // A clear in the same cycle as a symbol makes the history look empty.
  always_comb begin
    vld_eff_p0 = clear ? '0 : hist_vld;
    if (mode) mult_p0 = window_count(vld_eff_p0, hist_data, in_data) + MW'(1);
    else      mult_p0 = run_count(vld_eff_p0, hist_data, in_data) + MW'(1);
  end

  // ---- p0 -> p1 boundary: registered result and history valid bits ----
  // Control path: result strobe, multiplicity, flags and history valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld   <= '0;
      out_valid  <= 1'b0;
      out_mult   <= '0;
      out_pair   <= 1'b0;
      out_triple <= 1'b0;
      out_many   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_mult   <= mult_p0;
        out_pair   <= (mult_p0 == MW'(2));
        out_triple <= (mult_p0 == MW'(3));
        out_many   <= (mult_p0 >= MW'(4));
        hist_vld   <= {vld_eff_p0[DEPTH-2:0], 1'b1};
      end else begin
        out_mult   <= '0;
        out_pair   <= 1'b0;
        out_triple <= 1'b0;
        out_many   <= 1'b0;
        if (clear) hist_vld <= '0;
      end
    end
  end

  // Data path: symbol history shifts on every accepted symbol, no reset needed
  // because the valid bits gate every compare.
  always_ff @(posedge clk) begin
    if (in_valid) hist_data <= {hist_data[DEPTH-2:0], in_data};
  end

`ifdef MULT_DETECT_EVENT_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // ---- p1 -> p2 boundary: event counters follow the registered flags ----
  // Saturating counters of pair and triple results.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pair_cnt   <= '0;
      triple_cnt <= '0;
    end else begin
      if (out_pair)   pair_cnt   <= sat_inc(pair_cnt);
      if (out_triple) triple_cnt <= sat_inc(triple_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_multiplicity_window_detector.sv
// Bench for multiplicity_window_detector (WIDTH=4, DEPTH=7): directed scenarios
// plus randomized traffic, checked against a queue-based symbol history model.
module tb_multiplicity_window_detector;

  localparam int WIDTH = 4;
  localparam int DEPTH = 7;
  localparam int MW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             mode = 1'b0;
  logic             clear = 1'b0;
  logic             out_valid;
  logic [MW-1:0]    out_mult;
  logic             out_pair, out_triple, out_many;
`ifdef MULT_DETECT_EVENT_CNT_EN
  logic [7:0]       pair_cnt, triple_cnt;
`endif

  multiplicity_window_detector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .mode(mode),
    .clear(clear), .out_valid(out_valid), .out_mult(out_mult), .out_pair(out_pair),
    .out_triple(out_triple), .out_many(out_many)
`ifdef MULT_DETECT_EVENT_CNT_EN
    , .pair_cnt(pair_cnt), .triple_cnt(triple_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;
  int hist[$];   // newest symbol at index 0

  // Reference: multiplicity of sym given the symbols seen so far.
  function automatic int model_mult(int sym, bit md, bit clr);
    int m = 0;
    if (clr) return 1;
    if (md) begin
      foreach (hist[i]) if (hist[i] == sym) m++;
    end else begin
      for (int i = 0; i < hist.size(); i++) begin
        if (hist[i] != sym) break;
        m++;
      end
    end
    return m + 1;
  endfunction

  function automatic void model_push(int sym, bit clr);
    if (clr) hist.delete();
    hist.push_front(sym);
    if (hist.size() > DEPTH) void'(hist.pop_back());
  endfunction

  task automatic send(input int sym, input bit md, input bit clr, input string tag,
                      output int got);
    int exp;
    logic [MW-1:0] expm;
    exp = model_mult(sym, md, clr);
    expm = exp[MW-1:0];
    model_push(sym, clr);
    in_valid = 1'b1; in_data = sym[WIDTH-1:0]; mode = md; clear = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_mult !== expm || out_pair !== (exp == 2) ||
        out_triple !== (exp == 3) || out_many !== (exp >= 4)) begin
      fails++;
      $display("FAIL %s sym=%0d mode=%0d: got vld=%b mult=%0d p/t/m=%b%b%b, want vld=1 mult=%0d p/t/m=%b%b%b",
               tag, sym, md, out_valid, out_mult, out_pair, out_triple, out_many,
               exp, exp == 2, exp == 3, exp >= 4);
    end
    got = int'(out_mult);
  endtask

  task automatic idle(input bit clr, input string tag);
    in_valid = 1'b0; clear = clr;
    if (clr) hist.delete();
    @(posedge clk); #1;
    clear = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_pair !== 1'b0 || out_triple !== 1'b0 || out_many !== 1'b0) begin
      fails++;
      $display("FAIL %s: got vld=%b p/t/m=%b%b%b, want all 0", tag, out_valid, out_pair,
               out_triple, out_many);
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int want);
    tests_run++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic test_reset();
    int got;
    rst = 1'b1; in_valid = 1'b1; in_data = 4'd5; mode = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_int("reset_out_valid", int'(out_valid), 0);
    expect_int("reset_out_mult", int'(out_mult), 0);
    expect_int("reset_flags", int'({out_pair, out_triple, out_many}), 0);
    rst = 1'b0; in_valid = 1'b0;
    hist.delete();
    send(5, 1'b1, 1'b0, "first_symbol", got);
    expect_int("first_symbol_mult", got, 1);
  endtask

  task automatic test_window();
    int seq[5] = '{3, 9, 3, 1, 3};
    int got;
    idle(1'b1, "window_clear");
    foreach (seq[i]) send(seq[i], 1'b1, 1'b0, "window_seq", got);
    expect_int("window_final_mult", got, 3);
    expect_int("window_final_triple", int'(out_triple), 1);
  endtask

  task automatic test_run();
    int seq[5] = '{3, 9, 3, 1, 3};
    int got;
    idle(1'b1, "run_clear");
    foreach (seq[i]) send(seq[i], 1'b0, 1'b0, "run_seq", got);
    expect_int("run_final_mult", got, 1);
    for (int i = 0; i < 3; i++) begin
      send(3, 1'b0, 1'b0, "run_repeat", got);
      expect_int("run_repeat_mult", got, i + 2);
    end
    expect_int("run_many_flag", int'(out_many), 1);
    idle(1'b1, "run_sat_clear");
    for (int i = 0; i < 9; i++) begin
      send(6, 1'b0, 1'b0, "run_sat", got);
      if (i >= 7) expect_int("run_saturate", got, DEPTH + 1);
    end
  endtask

  task automatic test_wrap();
    int got;
    idle(1'b1, "wrap_clear");
    send(7, 1'b1, 1'b0, "wrap6", got);
    for (int i = 0; i < 6; i++) send(i, 1'b1, 1'b0, "wrap6", got);
    send(7, 1'b1, 1'b0, "wrap6", got);
    expect_int("wrap_six_between", got, 2);
    idle(1'b1, "wrap_clear2");
    send(7, 1'b1, 1'b0, "wrap7", got);
    for (int i = 0; i < 7; i++) send(i, 1'b1, 1'b0, "wrap7", got);
    send(7, 1'b1, 1'b0, "wrap7", got);
    expect_int("wrap_seven_between", got, 1);
  endtask

  task automatic test_clear();
    int got;
    idle(1'b1, "clear_pre");
    send(2, 1'b1, 1'b0, "clear_seq", got);
    send(2, 1'b1, 1'b0, "clear_seq", got);
    send(2, 1'b1, 1'b1, "clear_with_symbol", got);
    expect_int("clear_with_symbol_mult", got, 1);
    send(2, 1'b1, 1'b0, "clear_after", got);
    expect_int("clear_after_mult", got, 2);
  endtask

  task automatic test_back_to_back();
    int got;
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      idle(1'b0, "rand_idle");
      else if (r == 1) idle(1'b1, "rand_clear");
      else send($urandom_range(0, 3), 1'($urandom_range(0, 1)), r == 2, "rand", got);
    end
  endtask

`ifdef MULT_DETECT_EVENT_CNT_EN
  task automatic test_counters();
    int seq[9] = '{1, 1, 2, 2, 3, 3, 4, 4, 4};
    int got;
    idle(1'b1, "cnt_clear");
    foreach (seq[i]) send(seq[i], 1'b1, 1'b0, "cnt_seq", got);
    idle(1'b0, "cnt_settle");
    expect_int("pair_cnt", int'(pair_cnt), 4);
    expect_int("triple_cnt", int'(triple_cnt), 1);
    send(4, 1'b1, 1'b0, "cnt_more", got);
    rst = 1'b1; in_valid = 1'b1; in_data = 4'd4;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    hist.delete();
    expect_int("pair_cnt_after_rst", int'(pair_cnt), 0);
    expect_int("triple_cnt_after_rst", int'(triple_cnt), 0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_window();
    test_run();
    test_wrap();
    test_clear();
    test_back_to_back();
`ifdef MULT_DETECT_EVENT_CNT_EN
    test_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
